mdio_phy_slave: RTL and testbench
=================================

# mdio_phy_slave

PHY-side Clause 22 MDIO management responder: the counterpart to the MAC's MDIO master on the GMII management signals. Oversamples MDIO_MDC and MDIO_O in the fabric clock domain and decodes read/write frames addressed to its PHY address. Drives MDIO_I and MDIO_PHY_TN, and exposes a simple strobe-based register port to the PHY's management register file. Sits beside the PHY datapath on the `phy` side of the GMII interface.

## Interface
- PHY_ADDR, 5'd0: PHY address this responder answers to.
- PREAMBLE_LEN, 32: consecutive 1s required before a start-of-frame is accepted (1..32).
- CLK  input  1  fabric clock; one clock for the whole block.
- RSTN  input  1  reset, asynchronous, active-low.
- MDIO_MDC  input  1  management clock from the MAC, asynchronous to CLK.
- MDIO_O  input  1  management data, MAC to PHY.
- MDIO_I  output  1  management data, PHY to MAC.
- MDIO_PHY_TN  output  1  PHY tristate control: 1 = release (receive), 0 = drive MDIO_I.
- REG_ADDR  output  5  register address of the current frame.
- REG_WDATA  output  16  write data; valid while REG_WR is high.
- REG_WR  output  1  one-CLK write strobe.
- REG_RD  output  1  one-CLK read strobe.
- REG_RDATA  input  16  read data; sampled exactly 2 CLK after REG_RD is asserted.

## Operation
- MDIO_MDC and MDIO_O each pass through 2 flops. A rising edge of synchronized MDC produces a one-CLK `tick`. Every bit decision uses synchronized MDIO_O at the `tick`.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA.
- IDLE: a 6-bit ones counter increments on each sampled 1 and saturates at PREAMBLE_LEN.
  - A sampled 0 with count ≥ PREAMBLE_LEN moves to ST; this 0 is ST bit 0.
  - Any other 0 clears the count.
- ST: a sampled 1 moves to OP. A sampled 0 returns to IDLE with count 0.
- OP: shifts in 2 bits. 10 = read, 01 = write. 00 or 11 returns to IDLE with count 0.
- PHYAD: shifts in 5 bits MSB first. A mismatch with PHY_ADDR returns to IDLE with count 0; nothing is driven and no strobe is issued.
- REGAD: shifts in 5 bits MSB first and loads REG_ADDR.
  - On a read, REG_RD pulses on the CLK after the last REGAD tick.
  - REG_RDATA is captured into the 16-bit output shift register 2 CLK after REG_RD.
- TA, write: 2 ticks are ignored, then WDATA.
- TA, read: the first tick keeps MDIO_PHY_TN=1. The second tick sets MDIO_PHY_TN=0 and MDIO_I=0.
- RDATA: on each of the next 16 ticks, MDIO_I is set to the next data bit, D15 first.
  - The tick after D0 releases the line (MDIO_PHY_TN=1, MDIO_I=1) and returns to IDLE with count 0.
- WDATA: shifts in 16 bits MSB first.
  - On the CLK after the D0 tick, REG_WDATA is loaded and REG_WR pulses for 1 CLK.
  - The state returns to IDLE with count 0.
- MDIO_I is 1 whenever the block is not driving.

## Timing
- Reset values: MDIO_I=1, MDIO_PHY_TN=1, REG_WR=0, REG_RD=0, REG_ADDR=0, REG_WDATA=0. State is IDLE with ones count 0.
- Output latency: MDIO_I and MDIO_PHY_TN change no later than 4 CLK after the MDC rising edge at the pin. This must stay within the 300 ns Clause 22 output delay.
- Clock ratio: the CLK period must be ≤ 1/8 of the MDC period and ≤ 75 ns.
- REG_RD and REG_WR are never asserted in the same cycle. Each is at most 1 CLK wide per frame.
- MDC stalling mid-frame: no timeout; the frame resumes on the next tick.
- Reset mid-frame: all outputs go to reset values asynchronously and the line is released immediately. No strobe fires for the aborted frame.
- Back-to-back frames: a new frame needs a full PREAMBLE_LEN preamble after the previous frame's last bit.

## Structure
- Package mdio_pkg holds:
  - the state enum;
  - OP_READ=2'b10 and OP_WRITE=2'b01;
  - widths (PHYAD_W=5, REGAD_W=5, DATA_W=16).
- Sub-module mdc_sync: 2-flop synchronizers for MDC and MDIO_O, plus rising-edge `tick` generation.
- The top level holds the FSM, the bit counter, the shift registers and the output registers.

## Test plan
- Write frame (32×1, 01, 01, PHYAD=PHY_ADDR, REGAD=5'h04, TA=10, data 16'hA5C3) -> REG_WR for exactly 1 CLK with REG_ADDR=5'h04 and REG_WDATA=16'hA5C3; MDIO_PHY_TN stays 1 throughout.
- Read frame of REGAD=5'h02, with REG_RDATA=16'h0141 returned 2 CLK after REG_RD -> MAC samples 0 in TA bit 2, then 0000_0001_0100_0001; MDIO_PHY_TN=0 for exactly 17 MDC periods.
- Read and write frames with PHYAD=PHY_ADDR^5'h01 -> no REG_RD, no REG_WR, MDIO_PHY_TN stays 1; a following valid frame is accepted.
- Frame with only 31 preamble 1s (PREAMBLE_LEN=32) -> ignored. Frame with OP=11 -> ignored, no strobe.
- Assert RSTN low on the 8th RDATA bit -> MDIO_PHY_TN=1 and MDIO_I=1 within the same cycle; after release, a full valid write is decoded correctly.
- MDC/CLK ratio of exactly 8 with MDC held high for 1 µs mid-frame -> frame still decoded, and output changes within 4 CLK of each MDC rise.

Source files
------------

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the Clause 22 MDIO PHY responder.
// Frame state enum, opcode values and field widths.
package mdio_pkg;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA
  } state_e;
endpackage

// File: rtl/mdio_phy_slave_if.sv
// mdio_phy_slave_if: MDIO pins (MDC, MDIO_O in; MDIO_I, MDIO_PHY_TN out)
// plus the strobe register port (REG_ADDR/WDATA/WR/RD out, REG_RDATA in).
interface mdio_phy_slave_if;
  import mdio_pkg::*;

  logic                MDIO_MDC;
  logic                MDIO_O;
  logic                MDIO_I;
  logic                MDIO_PHY_TN;
  logic [REGAD_W-1:0]  REG_ADDR;
  logic [DATA_W-1:0]   REG_WDATA;
  logic                REG_WR;
  logic                REG_RD;
  logic [DATA_W-1:0]   REG_RDATA;

  modport slave (
    input  MDIO_MDC, MDIO_O, REG_RDATA,
    output MDIO_I, MDIO_PHY_TN, REG_ADDR,
    output REG_WDATA, REG_WR, REG_RD
  );

  modport master (
    output MDIO_MDC, MDIO_O, REG_RDATA,
    input  MDIO_I, MDIO_PHY_TN, REG_ADDR,
    input  REG_WDATA, REG_WR, REG_RD
  );
endinterface

// File: rtl/mdc_sync.sv
// mdc_sync: 2-flop synchronizers for MDC/MDIO_O and MDC rising-edge tick.
// Ports: i_clk, i_rst_n, i_mdc, i_mdo in; o_tick, o_mdo out.
module mdc_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mdc,
  input  logic i_mdo,
  output logic o_tick,
  output logic o_mdo
);
  logic [2:0] r_mdc;
  logic [1:0] r_mdo;

  // Reset to 1s so an MDC already high at reset release is not a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mdc <= 3'b111;
      r_mdo <= 2'b11;
    end else begin
      r_mdc <= {r_mdc[1:0], i_mdc};
      r_mdo <= {r_mdo[0], i_mdo};
    end
  end

  assign o_tick = r_mdc[1] & ~r_mdc[2];
  assign o_mdo  = r_mdo[1];
endmodule

// File: rtl/mdio_phy_slave.sv
// mdio_phy_slave: Clause 22 MDIO responder, decodes frames for PHY_ADDR.
// Ports: CLK, RSTN (async low), bus (mdio_phy_slave_if.slave).
module mdio_phy_slave
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd0,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic CLK,
  input  logic RSTN,
  mdio_phy_slave_if.slave bus
);
  localparam logic [5:0] PRE = 6'(PREAMBLE_LEN);

  logic w_tick;
  logic w_mdo;

  state_e              r_state, w_state_n;
  logic [4:0]          r_bit, w_bit_n;
  logic [5:0]          r_ones, w_ones_n;
  logic [DATA_W-2:0]   r_sr, w_sr_n;
  logic [1:0]          r_op, w_op_n;
  logic [DATA_W-1:0]   r_out, w_out_n;
  logic                r_rd_d1;
  logic                r_mdio_i, w_mdio_i_n;
  logic                r_tn, w_tn_n;
  logic [REGAD_W-1:0]  r_addr, w_addr_n;
  logic [DATA_W-1:0]   r_wdata, w_wdata_n;
  logic                r_wr, w_wr_n;
  logic                r_rd, w_rd_n;

  mdc_sync u_sync (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_mdc   (bus.MDIO_MDC),
    .i_mdo   (bus.MDIO_O),
    .o_tick  (w_tick),
    .o_mdo   (w_mdo)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= IDLE;
      r_bit    <= '0;
      r_ones   <= '0;
      r_sr     <= '0;
      r_op     <= '0;
      r_out    <= '0;
      r_rd_d1  <= 1'b0;
      r_mdio_i <= 1'b1;
      r_tn     <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_bit    <= w_bit_n;
      r_ones   <= w_ones_n;
      r_sr     <= w_sr_n;
      r_op     <= w_op_n;
      r_out    <= w_out_n;
      r_rd_d1  <= r_rd;
      r_mdio_i <= w_mdio_i_n;
      r_tn     <= w_tn_n;
      r_addr   <= w_addr_n;
      r_wdata  <= w_wdata_n;
      r_wr     <= w_wr_n;
      r_rd     <= w_rd_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_bit_n    = r_bit;
    w_ones_n   = r_ones;
    w_sr_n     = r_sr;
    w_op_n     = r_op;
    w_out_n    = r_out;
    w_mdio_i_n = r_mdio_i;
    w_tn_n     = r_tn;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    w_wr_n     = 1'b0;
    w_rd_n     = 1'b0;
    // Register file answers two CLK after the read strobe.
    if (r_rd_d1) w_out_n = bus.REG_RDATA;
    if (w_tick) begin
      w_sr_n  = {r_sr[DATA_W-3:0], w_mdo};
      w_bit_n = r_bit + 5'd1;
      unique case (r_state)
        IDLE: begin
          w_bit_n = '0;
          if (w_mdo) begin
            if (r_ones != PRE) w_ones_n = r_ones + 6'd1;
          end else if (r_ones == PRE) begin
            w_state_n = ST;
            w_ones_n  = '0;
          end else begin
            w_ones_n = '0;
          end
        end
        ST: begin
          w_bit_n   = '0;
          w_state_n = w_mdo ? OP : IDLE;
        end
        OP: if (r_bit == 5'd1) begin
          w_bit_n   = '0;
          w_op_n    = {r_sr[0], w_mdo};
          w_state_n = ({r_sr[0], w_mdo} == OP_READ ||
                       {r_sr[0], w_mdo} == OP_WRITE) ? PHYAD : IDLE;
        end
        PHYAD: if (r_bit == 5'd4) begin
          w_bit_n   = '0;
          w_state_n = ({r_sr[3:0], w_mdo} == PHY_ADDR) ? REGAD : IDLE;
        end
        REGAD: if (r_bit == 5'd4) begin
          w_bit_n   = '0;
          w_addr_n  = {r_sr[3:0], w_mdo};
          w_rd_n    = (r_op == OP_READ);
          w_state_n = TA;
        end
        TA: if (r_bit == 5'd1) begin
          w_bit_n = '0;
          if (r_op == OP_READ) begin
            w_tn_n     = 1'b0;
            w_mdio_i_n = 1'b0;
            w_state_n  = RDATA;
          end else begin
            w_state_n = WDATA;
          end
        end
        WDATA: if (r_bit == 5'd15) begin
          w_bit_n   = '0;
          w_wdata_n = {r_sr, w_mdo};
          w_wr_n    = 1'b1;
          w_state_n = IDLE;
        end
        RDATA: if (r_bit == 5'd16) begin
          w_bit_n    = '0;
          w_tn_n     = 1'b1;
          w_mdio_i_n = 1'b1;
          w_state_n  = IDLE;
        end else begin
          w_mdio_i_n = r_out[DATA_W-1];
          w_out_n    = {r_out[DATA_W-2:0], 1'b0};
        end
        default: begin
          w_bit_n   = '0;
          w_state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.MDIO_I      = r_mdio_i;
  assign bus.MDIO_PHY_TN = r_tn;
  assign bus.REG_ADDR    = r_addr;
  assign bus.REG_WDATA   = r_wdata;
  assign bus.REG_WR      = r_wr;
  assign bus.REG_RD      = r_rd;
endmodule

// File: tb/tb_mdio_phy_slave.sv
// tb_mdio_phy_slave: MAC-side frame driver, register-file responder and
// frame-level reference model for mdio_phy_slave.
module tb_mdio_phy_slave;
  import mdio_pkg::OP_READ;
  import mdio_pkg::OP_WRITE;

  localparam logic [4:0] PA  = 5'h0B;
  localparam int         PRE = 32;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;

  mdio_phy_slave_if bus ();

  mdio_phy_slave #(
    .PHY_ADDR     (PA),
    .PREAMBLE_LEN (PRE)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [4:0] a);
    if (a == 5'd2) return 16'h0141;
    return (16'(a) * 16'h1357) ^ 16'h9C4E;
  endfunction

  // Register file seen by the DUT, updated only by observed write strobes.
  logic [15:0] rf [32];
  bit          rf_v [32];
  function automatic logic [15:0] rf_val(input logic [4:0] a);
    return rf_v[a] ? rf[a] : init_val(a);
  endfunction

  // Reference contents, updated only by the model from frames sent.
  logic [15:0] ref_mem [32];
  bit          ref_v [32];
  function automatic logic [15:0] ref_val(input logic [4:0] a);
    return ref_v[a] ? ref_mem[a] : init_val(a);
  endfunction

  int          n_wr = 0, n_rd = 0, n_ovl = 0;
  logic [4:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;

  always @(negedge CLK) begin
    if (bus.REG_WR) begin
      n_wr++;
      wr_addr = bus.REG_ADDR;
      wr_data = bus.REG_WDATA;
      rf[bus.REG_ADDR]   = bus.REG_WDATA;
      rf_v[bus.REG_ADDR] = 1'b1;
    end
    if (bus.REG_RD) begin
      n_rd++;
      rd_addr = bus.REG_ADDR;
    end
    if (bus.REG_WR && bus.REG_RD) n_ovl++;
  end

  // Valid data only in the single CLK where it must be captured.
  logic [1:0] rd_pipe = '0;
  always @(posedge CLK) begin
    #1;
    rd_pipe = {rd_pipe[0], bus.REG_RD};
    bus.REG_RDATA = rd_pipe[1] ? rf_val(bus.REG_ADDR) : 16'($urandom);
  end

  int hp = 5;
  bit smp_i [$];
  bit smp_tn [$];

  // One MDC period; the MAC looks at the PHY pins 4 CLK after the rise.
  task automatic mdc_bit(input bit b, input bit stall, input bit abort);
    bus.MDIO_O = b;
    repeat (hp) @(posedge CLK);
    #1 bus.MDIO_MDC = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    smp_i.push_back(bus.MDIO_I);
    smp_tn.push_back(bus.MDIO_PHY_TN);
    if (abort) begin
      chk("abort_pre_tn", 32'(bus.MDIO_PHY_TN), 32'd0);
      RSTN = 1'b0;
      #1;
      chk("abort_tn", 32'(bus.MDIO_PHY_TN), 32'd1);
      chk("abort_i", 32'(bus.MDIO_I), 32'd1);
      chk("abort_rd", 32'(bus.REG_RD), 32'd0);
      chk("abort_wr", 32'(bus.REG_WR), 32'd0);
      bus.MDIO_MDC = 1'b0;
      return;
    end
    repeat (hp - 4) @(posedge CLK);
    if (stall) repeat (100) @(posedge CLK);
    #1 bus.MDIO_MDC = 1'b0;
  endtask

  task automatic send_frame(input int pre, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] d, input int abort_at,
                            input int stall_at);
    bit q [$];
    int w0, r0, o0, tl, bi;
    bit valid, exp_wr, exp_rd;
    logic [15:0] word;
    q.push_back(1'b0);
    repeat (pre) q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(op[1]);
    q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    if (op == OP_WRITE) begin
      q.push_back(1'b1);
      q.push_back(1'b0);
      for (int i = 15; i >= 0; i--) q.push_back(d[i]);
    end else begin
      repeat (18) q.push_back(1'b1);
    end
    q.push_back(1'b1);
    smp_i.delete();
    smp_tn.delete();
    w0 = n_wr;
    r0 = n_rd;
    o0 = n_ovl;
    foreach (q[i]) begin
      mdc_bit(q[i], i == stall_at, i == abort_at);
      if (i == abort_at) break;
    end
    if (abort_at >= 0) return;
    repeat (4) @(posedge CLK);
    #1;
    valid  = (pre >= PRE) && (phy == PA) &&
             (op == OP_READ || op == OP_WRITE);
    exp_wr = valid && (op == OP_WRITE);
    exp_rd = valid && (op == OP_READ);
    chk("wr_cycles", 32'(n_wr - w0), 32'(exp_wr));
    chk("rd_cycles", 32'(n_rd - r0), 32'(exp_rd));
    chk("rd_wr_overlap", 32'(n_ovl - o0), 32'd0);
    if (exp_wr) begin
      chk("wr_addr", 32'(wr_addr), 32'(ra));
      chk("wr_data", 32'(wr_data), 32'(d));
      ref_mem[ra] = d;
      ref_v[ra]   = 1'b1;
    end
    if (exp_rd) begin
      chk("rd_addr", 32'(rd_addr), 32'(ra));
      chk("ta2_bit", 32'(smp_i[pre + 16]), 32'd0);
      for (int j = 0; j < 16; j++) word[15 - j] = smp_i[pre + 17 + j];
      chk("rdata", 32'(word), 32'(ref_val(ra)));
      chk("release_tn", 32'(smp_tn[pre + 33]), 32'd1);
    end
    tl = 0;
    bi = 0;
    foreach (smp_tn[i]) begin
      if (!smp_tn[i]) tl++;
      else if (!smp_i[i]) bi++;
    end
    chk("tn_low_periods", 32'(tl), exp_rd ? 32'd17 : 32'd0);
    chk("undriven_i_low", 32'(bi), 32'd0);
    chk("end_tn", 32'(bus.MDIO_PHY_TN), 32'd1);
    chk("end_i", 32'(bus.MDIO_I), 32'd1);
  endtask

  initial begin
    logic [1:0] op;
    logic [4:0] phy;
    int r;
    bus.MDIO_MDC = 1'b0;
    bus.MDIO_O   = 1'b1;
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_i", 32'(bus.MDIO_I), 32'd1);
    chk("rst_tn", 32'(bus.MDIO_PHY_TN), 32'd1);
    chk("rst_wr", 32'(bus.REG_WR), 32'd0);
    chk("rst_rd", 32'(bus.REG_RD), 32'd0);
    chk("rst_addr", 32'(bus.REG_ADDR), 32'd0);
    chk("rst_wdata", 32'(bus.REG_WDATA), 32'd0);
    RSTN = 1'b1;
    repeat (3) @(posedge CLK);

    hp = 5;
    send_frame(32, OP_WRITE, PA, 5'h04, 16'hA5C3, -1, -1);
    send_frame(32, OP_READ, PA, 5'h02, 16'h0000, -1, -1);
    send_frame(32, OP_READ, PA ^ 5'h01, 5'h02, 16'h0000, -1, -1);
    send_frame(32, OP_WRITE, PA ^ 5'h01, 5'h07, 16'h1234, -1, -1);
    send_frame(32, OP_READ, PA, 5'h04, 16'h0000, -1, -1);
    send_frame(31, OP_WRITE, PA, 5'h05, 16'hBEEF, -1, -1);
    send_frame(32, 2'b11, PA, 5'h05, 16'hBEEF, -1, -1);
    send_frame(32, OP_READ, PA, 5'h05, 16'h0000, -1, -1);

    for (int k = 0; k < 14; k++) begin
      hp = $urandom_range(4, 6);
      r  = $urandom_range(0, 5);
      op = (r < 2) ? OP_WRITE : (r < 4) ? OP_READ :
           (r == 4) ? 2'b11 : 2'b00;
      phy = ($urandom_range(0, 3) == 0) ?
            (PA ^ 5'($urandom_range(1, 31))) : PA;
      send_frame($urandom_range(30, 34), op, phy, 5'($urandom),
                 16'($urandom), -1, -1);
    end

    hp = 5;
    send_frame(32, OP_READ, PA, 5'h04, 16'h0000, 32 + 24, -1);
    repeat (5) @(posedge CLK);
    #1 RSTN = 1'b1;
    repeat (3) @(posedge CLK);
    send_frame(32, OP_WRITE, PA, 5'h09, 16'h5A0F, -1, -1);
    send_frame(32, OP_READ, PA, 5'h09, 16'h0000, -1, -1);

    hp = 4;
    send_frame(32, OP_WRITE, PA, 5'h11, 16'hC0DE, -1, 40);
    send_frame(32, OP_READ, PA, 5'h11, 16'h0000, -1, 32 + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end
endmodule
